// File: rtl/brew_ctrl.sv
// Brew sequencer: button edge detect, IDLE/HEAT/BREW/DONE/FAULT sequencing on a ms timebase, registered Moore outputs (1 cycle).
// Optional feature macro BREW_PAUSE_EN adds a PAUSE state that freezes the brew timer; default build has no PAUSE.
module brew_ctrl #(
  parameter int CLK_HZ          = 50_000_000,
  parameter int HEAT_TIMEOUT_MS = 30_000,
  parameter int BREW_SMALL_MS   = 20_000,
  parameter int BREW_LARGE_MS   = 40_000,
  parameter int DONE_MS         = 3_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       cancel_btn,
  input  logic       size_large,
  input  logic       water_ok,
  input  logic       temp_ready,
  output logic       heater_on,
  output logic       pump_on,
  output logic       busy,
  output logic       done_led,
  output logic       fault,
  output logic [2:0] state_o
);

  localparam int TICKS  = CLK_HZ / 1000;
  localparam int PW     = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam int MAX_HB = (HEAT_TIMEOUT_MS > BREW_SMALL_MS) ? HEAT_TIMEOUT_MS : BREW_SMALL_MS;
  localparam int MAX_LD = (BREW_LARGE_MS > DONE_MS) ? BREW_LARGE_MS : DONE_MS;
  localparam int MAX_MS = (MAX_HB > MAX_LD) ? MAX_HB : MAX_LD;
  localparam int MW     = $clog2(MAX_MS) + 1;

  localparam logic [PW-1:0] PRESC_MAX  = PW'(TICKS - 1);
  localparam logic [MW-1:0] HEAT_LAST  = MW'(HEAT_TIMEOUT_MS - 1);
  localparam logic [MW-1:0] SMALL_LAST = MW'(BREW_SMALL_MS - 1);
  localparam logic [MW-1:0] LARGE_LAST = MW'(BREW_LARGE_MS - 1);
  localparam logic [MW-1:0] DONE_LAST  = MW'(DONE_MS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HEAT  = 3'd1,
    S_BREW  = 3'd2,
    S_DONE  = 3'd3,
    S_FAULT = 3'd4,
    S_PAUSE = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [MW-1:0] ms_q, ms_d;
  logic          size_q, size_d;
  logic          start_prev_q, start_prev_d;
  logic          cancel_prev_q, cancel_prev_d;
  logic          heater_q, heater_d;
  logic          pump_q, pump_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          fault_q, fault_d;

  logic start_evt, cancel_evt, ms_tick;
  logic heat_exp, brew_exp, done_exp;
  logic timer_frozen, timer_keep;

  assign start_evt     = start_btn & ~start_prev_q;
  assign cancel_evt    = cancel_btn & ~cancel_prev_q;
  assign start_prev_d  = start_btn;
  assign cancel_prev_d = cancel_btn;

  assign ms_tick  = (presc_q == PRESC_MAX);
  assign heat_exp = ms_tick && (ms_q == HEAT_LAST);
  assign brew_exp = ms_tick && (ms_q == (size_q ? LARGE_LAST : SMALL_LAST));
  assign done_exp = ms_tick && (ms_q == DONE_LAST);

  always_comb begin
    state_d = state_q;
    size_d  = size_q;
    case (state_q)
      S_IDLE: begin
        if (start_evt) begin
          if (water_ok) begin
            state_d = S_HEAT;
            size_d  = size_large;
          end else begin
            state_d = S_FAULT;
          end
        end
      end
      S_HEAT: begin
        // temp_ready outranks the timeout when both land in the same cycle
        if (cancel_evt)      state_d = S_IDLE;
        else if (!water_ok)  state_d = S_FAULT;
        else if (temp_ready) state_d = S_BREW;
        else if (heat_exp)   state_d = S_FAULT;
      end
      S_BREW: begin
        if (cancel_evt)      state_d = S_IDLE;
        else if (!water_ok)  state_d = S_FAULT;
        else if (brew_exp)   state_d = S_DONE;
`ifdef BREW_PAUSE_EN
        else if (start_evt)  state_d = S_PAUSE;
`endif
      end
      S_DONE: begin
        if (cancel_evt || done_exp) state_d = S_IDLE;
      end
      S_FAULT: begin
        if (cancel_evt) state_d = S_IDLE;
      end
`ifdef BREW_PAUSE_EN
      S_PAUSE: begin
        if (cancel_evt)     state_d = S_IDLE;
        else if (!water_ok) state_d = S_FAULT;
        else if (start_evt) state_d = S_BREW;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

`ifdef BREW_PAUSE_EN
  // BREW<->PAUSE keeps the elapsed brew time so total pump time is preserved
  assign timer_frozen = (state_q == S_PAUSE);
  assign timer_keep   = ((state_q == S_BREW) && (state_d == S_PAUSE)) ||
                        ((state_q == S_PAUSE) && (state_d == S_BREW));
`else
  assign timer_frozen = 1'b0;
  assign timer_keep   = 1'b0;
`endif

  always_comb begin
    presc_d = presc_q;
    ms_d    = ms_q;
    if ((state_d != state_q) && !timer_keep) begin
      presc_d = '0;
      ms_d    = '0;
    end else if (!timer_frozen) begin
      if (ms_tick) begin
        presc_d = '0;
        ms_d    = ms_q + MW'(1);
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  always_comb begin
    heater_d = (state_d == S_HEAT) || (state_d == S_BREW) || (state_d == S_PAUSE);
    pump_d   = (state_d == S_BREW);
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
    fault_d  = (state_d == S_FAULT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      presc_q       <= '0;
      ms_q          <= '0;
      size_q        <= 1'b0;
      start_prev_q  <= 1'b0;
      cancel_prev_q <= 1'b0;
      heater_q      <= 1'b0;
      pump_q        <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      presc_q       <= presc_d;
      ms_q          <= ms_d;
      size_q        <= size_d;
      start_prev_q  <= start_prev_d;
      cancel_prev_q <= cancel_prev_d;
      heater_q      <= heater_d;
      pump_q        <= pump_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      fault_q       <= fault_d;
    end
  end

  assign heater_on = heater_q;
  assign pump_on   = pump_q;
  assign busy      = busy_q;
  assign done_led  = done_q;
  assign fault     = fault_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_brew_ctrl.sv
// Directed bench for brew_ctrl at CLK_HZ=4000 (4 cycles per ms); table of per-cycle vectors plus brew/pause sequences.
module tb_brew_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_btn = 1'b0, cancel_btn = 1'b0, size_large = 1'b0;
  logic       water_ok = 1'b1, temp_ready = 1'b0;
  logic       heater_on, pump_on, busy, done_led, fault;
  logic [2:0] state_o;

  localparam logic [2:0] IDLE = 3'd0, HEAT = 3'd1, BREW = 3'd2, DONE = 3'd3, FLT = 3'd4, PAUSE = 3'd5;

  always #5 clk = ~clk;

  brew_ctrl #(
    .CLK_HZ(4000), .HEAT_TIMEOUT_MS(3), .BREW_SMALL_MS(5), .BREW_LARGE_MS(7), .DONE_MS(2)
  ) dut (
    .clk(clk), .rst(rst), .start_btn(start_btn), .cancel_btn(cancel_btn),
    .size_large(size_large), .water_ok(water_ok), .temp_ready(temp_ready),
    .heater_on(heater_on), .pump_on(pump_on), .busy(busy), .done_led(done_led),
    .fault(fault), .state_o(state_o)
  );

  typedef struct {
    int         n;
    logic       r, st, cn, sz, wo, tr;
    logic [2:0] exp_state;
  } vec_t;

  vec_t vecs[$];
  int   applied = 0;
  int   errs = 0;

  function automatic void add(int n, logic r, logic st, logic cn, logic sz, logic wo, logic tr, logic [2:0] s);
    vec_t v;
    v.n = n; v.r = r; v.st = st; v.cn = cn; v.sz = sz; v.wo = wo; v.tr = tr; v.exp_state = s;
    vecs.push_back(v);
  endfunction

  // {heater_on, pump_on, busy, done_led, fault} expected for each state
  function automatic logic [4:0] outs_for(logic [2:0] s);
    case (s)
      HEAT:    return 5'b10100;
      BREW:    return 5'b11100;
      DONE:    return 5'b00110;
      FLT:     return 5'b00101;
      PAUSE:   return 5'b10100;
      default: return 5'b00000;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string name, input logic [2:0] s);
    check(name, {24'd0, state_o, heater_on, pump_on, busy, done_led, fault},
          {24'd0, s, outs_for(s)});
  endtask

  task automatic drive(input logic r, input logic st, input logic cn, input logic sz, input logic wo, input logic tr);
    @(negedge clk);
    rst = r; start_btn = st; cancel_btn = cn; size_large = sz; water_ok = wo; temp_ready = tr;
    @(posedge clk);
    #1;
  endtask

  // Start edge at brew cycle 6 and again 50 cycles later; pump time must total 20 cycles either way.
  task automatic run_mid_brew_start();
    int   pump_n, pause_n, heat_drop, brew_len;
    logic got_done;
    pump_n = 0; pause_n = 0; heat_drop = 0; brew_len = 0; got_done = 1'b0;
    drive(0, 0, 0, 0, 1, 0);
    drive(0, 1, 0, 0, 1, 0);
    drive(0, 1, 0, 0, 1, 1);
    for (int c = 1; c <= 200; c++) begin
      if (state_o == DONE) begin
        got_done = 1'b1;
        brew_len = c;
        break;
      end
      if (pump_on) pump_n++;
      if (state_o == PAUSE) pause_n++;
      if (!heater_on) heat_drop++;
      drive(0, (c == 6 || c == 56), 0, 0, 1, 0);
    end
    check("mid_start_reached_done", {31'd0, got_done}, 32'd1);
    check("mid_start_pump_cycles", pump_n, 20);
    check("mid_start_heater_drops", heat_drop, 0);
`ifdef BREW_PAUSE_EN
    check("mid_start_pause_cycles", pause_n, 50);
    check("mid_start_done_at", brew_len, 71);
`else
    check("mid_start_pause_cycles", pause_n, 0);
    check("mid_start_done_at", brew_len, 21);
`endif
    drive(0, 0, 1, 0, 1, 0);
    check_state("mid_start_cancel_done", IDLE);
  endtask

  task automatic run_pause_cancel();
    drive(0, 0, 0, 0, 1, 0);
    drive(0, 1, 0, 0, 1, 0);
    drive(0, 1, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 1, 0);
    drive(0, 1, 0, 0, 1, 0);
`ifdef BREW_PAUSE_EN
    check_state("pause_entered", PAUSE);
`else
    check_state("start_ignored_in_brew", BREW);
`endif
    drive(0, 1, 1, 0, 1, 0);
    check_state("cancel_from_pause_or_brew", IDLE);
    drive(0, 0, 0, 0, 1, 0);
  endtask

  initial begin
    // reset
    add(2, 1, 0, 0, 0, 1, 0, IDLE);
    // small brew: 3 HEAT, 20 BREW, 8 DONE
    add(1, 0, 0, 0, 0, 1, 0, IDLE);
    add(1, 0, 1, 0, 0, 1, 0, HEAT);
    add(2, 0, 1, 0, 0, 1, 0, HEAT);
    add(1, 0, 1, 0, 0, 1, 1, BREW);
    add(19, 0, 0, 0, 0, 1, 0, BREW);
    add(8, 0, 0, 0, 0, 1, 0, DONE);
    add(2, 0, 0, 0, 0, 1, 0, IDLE);
    // large latched at start, size dropped in HEAT: 28 BREW; start held across DONE->IDLE
    add(1, 0, 1, 0, 1, 1, 0, HEAT);
    add(1, 0, 0, 0, 0, 1, 0, HEAT);
    add(1, 0, 0, 0, 0, 1, 1, BREW);
    add(27, 0, 0, 0, 0, 1, 1, BREW);
    add(1, 0, 0, 0, 0, 1, 0, DONE);
    add(7, 0, 1, 0, 0, 1, 0, DONE);
    add(4, 0, 1, 0, 0, 1, 0, IDLE);
    add(1, 0, 0, 0, 0, 1, 0, IDLE);
    add(1, 0, 1, 0, 0, 1, 0, HEAT);
    // cancel and water loss together in HEAT
    add(1, 0, 1, 1, 0, 0, 0, IDLE);
    // heat timeout after 12 cycles, FAULT ignores start, cancel clears
    add(1, 0, 0, 0, 0, 1, 0, IDLE);
    add(1, 0, 1, 0, 0, 1, 0, HEAT);
    add(11, 0, 1, 0, 0, 1, 0, HEAT);
    add(3, 0, 0, 0, 0, 1, 0, FLT);
    add(1, 0, 1, 0, 0, 1, 0, FLT);
    add(1, 0, 0, 0, 0, 1, 1, FLT);
    add(1, 0, 0, 1, 0, 1, 0, IDLE);
    // water loss mid-BREW
    add(1, 0, 0, 0, 0, 1, 0, IDLE);
    add(1, 0, 1, 0, 0, 1, 0, HEAT);
    add(1, 0, 1, 0, 0, 1, 1, BREW);
    add(4, 0, 0, 0, 0, 1, 0, BREW);
    add(1, 0, 0, 0, 0, 0, 0, FLT);
    add(2, 0, 0, 0, 0, 1, 0, FLT);
    add(1, 0, 0, 1, 0, 1, 0, IDLE);
    // start with no water in IDLE; water recovering keeps FAULT
    add(1, 0, 0, 0, 0, 0, 0, IDLE);
    add(1, 0, 1, 0, 0, 0, 0, FLT);
    add(3, 0, 0, 0, 0, 1, 0, FLT);
    add(1, 0, 0, 1, 0, 1, 0, IDLE);
    // reset mid-BREW
    add(1, 0, 0, 0, 0, 1, 0, IDLE);
    add(1, 0, 1, 0, 0, 1, 0, HEAT);
    add(1, 0, 1, 0, 0, 1, 1, BREW);
    add(3, 0, 1, 0, 0, 1, 0, BREW);
    add(1, 1, 0, 0, 0, 1, 0, IDLE);
    add(2, 0, 0, 0, 0, 1, 0, IDLE);
    // cancel in DONE and in BREW
    add(1, 0, 1, 0, 0, 1, 0, HEAT);
    add(1, 0, 1, 0, 0, 1, 1, BREW);
    add(19, 0, 0, 0, 0, 1, 0, BREW);
    add(3, 0, 0, 0, 0, 1, 0, DONE);
    add(1, 0, 0, 1, 0, 1, 0, IDLE);
    add(1, 0, 0, 0, 0, 1, 0, IDLE);
    add(1, 0, 1, 0, 0, 1, 0, HEAT);
    add(1, 0, 1, 0, 0, 1, 1, BREW);
    add(1, 0, 1, 1, 0, 1, 1, IDLE);

    for (int i = 0; i < vecs.size(); i++) begin
      for (int k = 0; k < vecs[i].n; k++) begin
        drive(vecs[i].r, vecs[i].st, vecs[i].cn, vecs[i].sz, vecs[i].wo, vecs[i].tr);
        check_state($sformatf("vec%0d.%0d", i, k), vecs[i].exp_state);
      end
    end

    run_mid_brew_start();
    run_pause_cancel();

    $display("== %0d vectors applied, %0d miscompares ==", applied, errs);
    $finish;
  end

endmodule

// File: doc/brew_ctrl.md
Name: brew_ctrl

Overview:
Top-level brew sequencer for the coffee maker. It takes debounced button levels and sensor levels, detects button presses, and runs the IDLE/HEAT/BREW/DONE/FAULT sequence. It drives the heater, pump and indicator outputs, using millisecond timers derived from the system clock. It sits between the per-button debounce instances and the actuator drivers.

Parameters:
CLK_HZ, 50_000_000, system clock frequency; CLK_HZ/1000 must be an integer ≥ 1.
HEAT_TIMEOUT_MS, 30_000, maximum time in HEAT waiting for temp_ready before FAULT.
BREW_SMALL_MS, 20_000, pump-on time for a small cup.
BREW_LARGE_MS, 40_000, pump-on time for a large cup.
DONE_MS, 3_000, time done_led is held before returning to IDLE.

Ports:
clk  input  1  system clock.
rst  input  1  synchronous, active-high reset.
start_btn  input  1  debounced start level; the action is on its rising edge.
cancel_btn  input  1  debounced cancel level; the action is on its rising edge.
size_large  input  1  cup size select: 1 = large, 0 = small; sampled at start.
water_ok  input  1  reservoir level sensor: 1 = sufficient water.
temp_ready  input  1  boiler at brew temperature.
heater_on  output  1  heater enable.
pump_on  output  1  pump enable.
busy  output  1  high in any state other than IDLE.
done_led  output  1  brew complete indicator.
fault  output  1  fault indicator.
state_o  output  3  current state: IDLE=0, HEAT=1, BREW=2, DONE=3, FAULT=4, PAUSE=5.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. All flops update on posedge clk.
- Reset values: state=IDLE, prescaler=0, ms counter=0, size latch=0, edge-detect history=0. All outputs are 0.
- Edge detect: start_evt = start_btn & ~start_prev; cancel_evt is formed the same way. The history registers update every cycle.
- Timebase:
  - The prescaler counts 0..CLK_HZ/1000-1; ms_tick is asserted on the cycle the prescaler equals its max.
  - ms_cnt increments on ms_tick.
  - Both the prescaler and ms_cnt clear on every state change.
  - A timed phase of D ms therefore lasts exactly D*(CLK_HZ/1000) cycles. It expires when ms_tick=1 and ms_cnt=D-1.
  - ms_cnt width is $clog2 of the largest duration parameter, plus 1.
- Outputs are a Moore decode of the state register: an event sampled in cycle N changes the outputs from cycle N+1.
  - heater_on = HEAT|BREW|PAUSE.
  - pump_on = BREW.
  - done_led = DONE.
  - fault = FAULT.
  - busy = state≠IDLE.
- Transition priority, highest first: cancel_evt > water fault > normal transition.
- IDLE:
  - start_evt with water_ok=1: latch size_large, go to HEAT.
  - start_evt with water_ok=0: go to FAULT.
  - Any other input is ignored.
- HEAT:
  - cancel_evt: go to IDLE.
  - water_ok=0: go to FAULT.
  - temp_ready=1: go to BREW.
  - HEAT_TIMEOUT_MS expires: go to FAULT.
  - If temp_ready=1 in the same cycle the timeout expires, go to BREW.
- BREW:
  - Duration is BREW_LARGE_MS or BREW_SMALL_MS according to the latched size; expiry goes to DONE.
  - cancel_evt: go to IDLE. water_ok=0: go to FAULT.
  - temp_ready is ignored in this state.
  - start_evt is ignored unless the optional feature is enabled.
- DONE:
  - DONE_MS expires: go to IDLE.
  - cancel_evt: go to IDLE immediately.
  - start_evt is ignored.
- FAULT:
  - Held until cancel_evt, then go to IDLE.
  - start_evt is ignored; water_ok recovering does not clear the fault.
- Reset mid-operation returns to IDLE with all outputs 0 on the next cycle, regardless of state.
- PAUSE and state code 5 are reachable only with the optional feature. Unused state codes decode to IDLE on the next cycle.

Optional Feature:
BREW_PAUSE_EN
- Defined:
  - start_evt in BREW goes to PAUSE: pump off, heater on.
  - In PAUSE, the prescaler and ms_cnt are frozen, not cleared.
  - start_evt in PAUSE returns to BREW, which resumes the remaining time.
  - In PAUSE, cancel_evt goes to IDLE and water_ok=0 goes to FAULT.
  - The BREW↔PAUSE transitions are exempt from the clear-on-state-change rule, so the total pump-on time is unchanged.
- Not defined: the PAUSE state is absent and start_evt in BREW is ignored.

Test Plan:
1. Normal small brew:
   - Setup: CLK_HZ=4000, BREW_SMALL_MS=5, DONE_MS=2; start edge with size_large=0, water_ok=1, temp_ready=1 three cycles later.
   - Expected: HEAT for 3 cycles, then pump_on high for exactly 20 cycles, done_led high for exactly 8 cycles, then IDLE with all outputs 0.
2. Large cup latch:
   - Setup: start with size_large=1, then drop size_large to 0 during HEAT; BREW_LARGE_MS=7.
   - Expected: pump_on lasts 28 cycles.
3. Heat timeout:
   - Setup: HEAT_TIMEOUT_MS=3, temp_ready held 0.
   - Expected: FAULT after exactly 12 cycles in HEAT; fault=1 until a cancel edge; start edges in FAULT are ignored; cancel gives IDLE.
4. Water loss and priority:
   - water_ok→0 mid-BREW: FAULT next cycle with pump_on=0.
   - cancel edge and water_ok=0 in the same cycle during HEAT: IDLE, not FAULT.
   - Start edge with water_ok=0 in IDLE: FAULT.
5. Edge-only triggering and reset:
   - start_btn held high across DONE→IDLE does not start a new brew until it falls and rises again.
   - rst asserted mid-BREW: IDLE with all outputs 0 on the next cycle.
6. Pause (BREW_PAUSE_EN defined):
   - Setup: BREW_SMALL_MS=5; start edge at brew cycle 6, hold PAUSE 50 cycles, start edge again.
   - Expected: total pump_on cycles = 20, heater_on stays high throughout, and a cancel during PAUSE gives IDLE.
